// File: rtl/sig_cond_pkg.sv
// Shared definitions for input-conditioning stages: debounce FSM state
// encoding and a constant-width helper.
package sig_cond_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    WAIT   = 1'b1
  } deb_state_e;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit.
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Plain shift chain; no logic between stages.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw input, producing a clean level plus
// single-cycle rise/fall strobes and a busy flag while a change qualifies.
module debounce_sync
  import sig_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic a_i,
  output logic a_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int unsigned CW     = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE          = (DEBOUNCE_CYCLES == 1);

  logic          s;
  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          a_q;
  logic          rise_q;
  logic          fall_q;

  sync_chain #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(RESET_LEVEL)
  ) u_sync (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .d_i    (a_i),
    .q_o    (s)
  );

  // Debounce FSM: qualifies a change of s over DEBOUNCE_CYCLES consecutive
  // edges, then commits the level and fires the matching strobe.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      a_q     <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        STABLE: begin
          if (s != a_q) begin
            if (SINGLE) begin
              a_q    <= s;
              rise_q <= s;
              fall_q <= ~s;
              cnt_q  <= '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CW'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT: begin
          if (s == a_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            a_q     <= s;
            rise_q  <= s;
            fall_q  <= ~s;
            state_q <= STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign a_o    = a_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = (state_q == WAIT);

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

  logic clk;
  logic arst_n;
  logic a_in;
  logic a0, rise0, fall0, busy0;
  logic a1, rise1, fall1, busy1;
  logic busy1_seen;

  int unsigned n_asserts;
  int unsigned n_fail;
  int unsigned rise_cnt;
  int unsigned fall_cnt;

  debounce_sync dut0 (
    .clk_i  (clk),
    .arst_ni(arst_n),
    .a_i    (a_in),
    .a_o    (a0),
    .rise_o (rise0),
    .fall_o (fall0),
    .busy_o (busy0)
  );

  debounce_sync #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(1),
    .RESET_LEVEL    (1'b0)
  ) dut1 (
    .clk_i  (clk),
    .arst_ni(arst_n),
    .a_i    (a_in),
    .a_o    (a1),
    .rise_o (rise1),
    .fall_o (fall1),
    .busy_o (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial busy1_seen = 1'b0;
  always @(posedge clk) if (busy1 === 1'b1) busy1_seen <= 1'b1;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    arst_n    = 1'b0;
    a_in      = 1'b0;
    #2;
    check_bit("rst_a", a0, 1'b0);
    check_bit("rst_busy", busy0, 1'b0);

    // Reset hold with toggling input
    for (int i = 0; i < 3; i++) begin
      a_in = ~a_in;
      tick();
      check_bit("rsthold_a", a0, 1'b0);
      check_bit("rsthold_rise", rise0, 1'b0);
      check_bit("rsthold_fall", fall0, 1'b0);
      check_bit("rsthold_busy", busy0, 1'b0);
    end
    a_in = 1'b0;
    tick();
    arst_n = 1'b1;
    repeat (4) tick();
    check_bit("idle_a", a0, 1'b0);
    check_bit("idle_busy", busy0, 1'b0);
    check_bit("idle_a1", a1, 1'b0);

    // Glitch: 1 for two capture edges, then back to 0
    a_in = 1'b1;
    tick();                                   // E0
    tick();                                   // E1
    a_in = 1'b0;
    check_bit("gl_busy_e1", busy0, 1'b0);
    tick();                                   // E2
    check_bit("gl_busy_e2", busy0, 1'b1);
    tick();                                   // E3
    check_bit("gl_busy_e3", busy0, 1'b1);
    tick();                                   // E4
    check_bit("gl_busy_e4", busy0, 1'b0);
    check_bit("gl_a_e4", a0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("gl_rise", rise0, 1'b0);
      check_bit("gl_a", a0, 1'b0);
    end

    // Clean rise
    a_in = 1'b1;
    tick();                                   // E0
    check_bit("rs_busy_e0", busy0, 1'b0);
    tick();                                   // E1
    check_bit("rs_busy_e1", busy0, 1'b0);
    check_bit("rs1_a_e1", a1, 1'b0);
    tick();                                   // E2
    check_bit("rs_busy_e2", busy0, 1'b1);
    check_bit("rs1_a_e2", a1, 1'b1);
    check_bit("rs1_rise_e2", rise1, 1'b1);
    tick();                                   // E3
    check_bit("rs1_rise_e3", rise1, 1'b0);
    tick();                                   // E4
    check_bit("rs_a_e4", a0, 1'b0);
    check_bit("rs_rise_e4", rise0, 1'b0);
    check_bit("rs_busy_e4", busy0, 1'b1);
    tick();                                   // E5
    check_bit("rs_a_e5", a0, 1'b1);
    check_bit("rs_rise_e5", rise0, 1'b1);
    check_bit("rs_fall_e5", fall0, 1'b0);
    check_bit("rs_busy_e5", busy0, 1'b0);
    tick();                                   // E6
    check_bit("rs_rise_e6", rise0, 1'b0);
    check_bit("rs_a_e6", a0, 1'b1);
    repeat (2) tick();

    // Clean fall
    a_in = 1'b0;
    repeat (5) tick();                        // E0..E4
    check_bit("fl_a_e4", a0, 1'b1);
    check_bit("fl_fall_e4", fall0, 1'b0);
    tick();                                   // E5
    check_bit("fl_a_e5", a0, 1'b0);
    check_bit("fl_fall_e5", fall0, 1'b1);
    check_bit("fl_rise_e5", rise0, 1'b0);
    tick();                                   // E6
    check_bit("fl_fall_e6", fall0, 1'b0);
    repeat (2) tick();

    // Reset in the middle of qualification
    a_in = 1'b1;
    repeat (4) tick();                        // E0..E3
    check_bit("rw_busy_e3", busy0, 1'b1);
    arst_n = 1'b0;
    #1;
    check_bit("rw_busy_rst", busy0, 1'b0);
    check_bit("rw_a_rst", a0, 1'b0);
    tick();
    check_bit("rw_rise_rst", rise0, 1'b0);
    arst_n = 1'b1;
    rise_cnt = 0;
    fall_cnt = 0;
    for (int k = 0; k < 9; k++) begin         // R0..R8
      tick();
      if (rise0 === 1'b1) rise_cnt++;
      if (fall0 === 1'b1) fall_cnt++;
      if (k == 0) check_bit("rw_rise_r0", rise0, 1'b0);
      if (k == 1) check_bit("rw_busy_r1", busy0, 1'b0);
      if (k == 2) check_bit("rw_busy_r2", busy0, 1'b1);
      if (k == 4) check_bit("rw_a_r4", a0, 1'b0);
      if (k == 5) begin
        check_bit("rw_a_r5", a0, 1'b1);
        check_bit("rw_rise_r5", rise0, 1'b1);
      end
    end
    check_bit("rw_one_rise", (rise_cnt == 1), 1'b1);
    check_bit("rw_no_fall", (fall_cnt == 0), 1'b1);

    check_bit("dc1_busy_never", busy1_seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
